// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, mid-bit sampling, LSB-first frame with
// a configurable stop interval. Presents each word with a one-cycle done strobe.
module uart_rx #(
    parameter int DATA_NBITS = 8,
    parameter int SB_TICK    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_tick,
    output logic [DATA_NBITS-1:0] o_data,
    output logic                  o_rx_done,
    output logic                  o_frame_err
);
    localparam int BW = (DATA_NBITS > 1) ? $clog2(DATA_NBITS) : 1;
    localparam logic [4:0]    START_MID = 5'd7;
    localparam logic [4:0]    DATA_LAST = 5'd15;
    localparam logic [4:0]    STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_NBITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state, state_nx;
    logic                    rx_meta, rx_s;
    logic [4:0]              tick_cnt, tick_cnt_nx;
    logic [BW-1:0]           bit_cnt, bit_cnt_nx;
    logic [DATA_NBITS-1:0]   shreg, shreg_nx;
    logic [DATA_NBITS-1:0]   data_nx;
    logic                    err_nx, done_nx;

    // Serial data arrives LSB first, so each new bit enters at the top.
    function automatic logic [DATA_NBITS-1:0] shift_in(input logic [DATA_NBITS-1:0] cur,
                                                       input logic bit_in);
        logic [DATA_NBITS-1:0] r;
        r = cur >> 1;
        r[DATA_NBITS-1] = bit_in;
        return r;
    endfunction

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            shreg       <= shreg_nx;
            o_data      <= data_nx;
            o_rx_done   <= done_nx;
            o_frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        data_nx     = o_data;
        err_nx      = o_frame_err;
        done_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                // Start search runs every clock, not only on ticks.
                if (!rx_s) begin
                    state_nx    = START;
                    tick_cnt_nx = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (tick_cnt == START_MID) begin
                        if (!rx_s) begin
                            state_nx    = DATA;
                            tick_cnt_nx = '0;
                            bit_cnt_nx  = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tick_cnt_nx = tick_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (tick_cnt == DATA_LAST) begin
                        shreg_nx    = shift_in(shreg, rx_s);
                        tick_cnt_nx = '0;
                        if (bit_cnt == BIT_LAST) state_nx = STOP;
                        else                     bit_cnt_nx = bit_cnt + BW'(1);
                    end else begin
                        tick_cnt_nx = tick_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        data_nx     = shreg;
                        err_nx      = ~rx_s;
                        done_nx     = 1'b1;
                        tick_cnt_nx = '0;
                        state_nx    = IDLE;
                    end else begin
                        tick_cnt_nx = tick_cnt + 5'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
